// File: rtl/seq101_pkg.sv
// Shared definitions for the "101" pattern transmitter and its detector bench.
package seq101_pkg;

  // Transmitter frame states: waiting, shifting data bits, emitting gap zeros
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // The serial pattern being counted; the detector bench uses the same constant
  localparam logic [2:0] MATCH_PATTERN = 3'b101;

endpackage

// File: rtl/seq101_tracker.sv
// Watches the emitted serial stream and counts overlapping "101" occurrences.
// History persists across frames and idle time so matches may straddle frames.
module seq101_tracker
  import seq101_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             x_out,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt
);

  logic [1:0] hist;

  // Mealy match: the two previous stream bits plus the current bit form the pattern
  assign match_pulse = bit_valid
                    && (hist == MATCH_PATTERN[2:1])
                    && (x_out == MATCH_PATTERN[0]);

  // Shift history only on real stream bits; count matches, saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist      <= 2'b00;
      match_cnt <= '0;
    end else begin
      if (bit_valid) begin
        hist <= {hist[0], x_out};
      end
      if (match_pulse && (match_cnt != '1)) begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq101_pattern_tx.sv
// Serial pattern transmitter: accepts parallel words on a valid/ready handshake,
// shifts each out MSB-first, then appends GAP zero bits. A word accepted on the
// final bit of a frame follows with no idle cycle in between.
module seq101_pattern_tx
  import seq101_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt
);

  // One down-counter serves both data and gap phases, sized for the longer one
  localparam int CNT_MAX = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;

  // Final bit of a frame: end of gap, or end of data when there is no gap
  assign last = (cnt == '0)
             && ((state == S_GAP) || ((state == S_SHIFT) && (GAP == 0)));

  // All stream outputs decode from registered state only, never from load
  assign ready     = (state == S_IDLE) || last;
  assign accept    = load && ready;
  assign x_out     = (state == S_SHIFT) && shreg[WIDTH-1];
  assign bit_valid = (state != S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = last;

  // Frame sequencer: load a word, shift data bits, count gap bits, chain next word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_SHIFT;
            shreg <= data_in;
            cnt   <= CW'(WIDTH - 1);
          end
        end
        S_SHIFT: begin
          if (cnt != '0) begin
            cnt   <= cnt - 1'b1;
            shreg <= {shreg[WIDTH-2:0], 1'b0};
          end else if (GAP != 0) begin
            state <= S_GAP;
            cnt   <= CW'(GAP - 1);
            shreg <= '0;
          end else if (accept) begin
            shreg <= data_in;
            cnt   <= CW'(WIDTH - 1);
          end else begin
            state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (accept) begin
            state <= S_SHIFT;
            shreg <= data_in;
            cnt   <= CW'(WIDTH - 1);
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Stream history and match counting
  seq101_tracker #(
    .CNT_W(CNT_W)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (bit_valid),
    .x_out      (x_out),
    .match_pulse(match_pulse),
    .match_cnt  (match_cnt)
  );

endmodule

// File: tb/tb_seq101_pattern_tx.sv
// Scoreboard bench for seq101_pattern_tx. Unit A: WIDTH 8, GAP 1, 2-bit counter
// (so saturation is reached quickly). Unit B: WIDTH 8, GAP 0, 16-bit counter.
module tb_seq101_pattern_tx;

  typedef struct {
    logic x;
    logic p;
    logic d;
  } exp_t;

  logic clk;
  logic rst;

  logic [7:0]  dataA, dataB;
  logic        loadA, loadB;
  logic        readyA, readyB;
  logic        xA, xB;
  logic        bvA, bvB;
  logic        busyA, busyB;
  logic        doneA, doneB;
  logic        pA, pB;
  logic [1:0]  cntA;
  logic [15:0] cntB;

  exp_t qA[$];
  exp_t qB[$];

  int passCount  = 0;
  int checkCount = 0;

  seq101_pattern_tx #(.WIDTH(8), .GAP(1), .CNT_W(2)) dutA (
    .clk        (clk),
    .rst        (rst),
    .data_in    (dataA),
    .load       (loadA),
    .ready      (readyA),
    .x_out      (xA),
    .bit_valid  (bvA),
    .busy       (busyA),
    .done       (doneA),
    .match_pulse(pA),
    .match_cnt  (cntA)
  );

  seq101_pattern_tx #(.WIDTH(8), .GAP(0), .CNT_W(16)) dutB (
    .clk        (clk),
    .rst        (rst),
    .data_in    (dataB),
    .load       (loadB),
    .ready      (readyB),
    .x_out      (xB),
    .bit_valid  (bvB),
    .busy       (busyB),
    .done       (doneB),
    .match_pulse(pB),
    .match_cnt  (cntB)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Wait for ready on the chosen unit, present one word, queue its hand-computed bits
  task automatic applyStimulus(input bit sel, input logic [7:0] word,
                               input logic [8:0] xv, input logic [8:0] pv,
                               input int len);
    int   n;
    bit   rdy;
    exp_t e;
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      rdy = (sel == 1'b0) ? readyA : readyB;
      n++;
    end
    if (!rdy) begin
      checkOutput(sel ? "B ready timeout" : "A ready timeout", 16'd0, 16'd1);
      return;
    end
    if (sel == 1'b0) begin
      loadA = 1'b1;
      dataA = word;
    end else begin
      loadB = 1'b1;
      dataB = word;
    end
    for (int i = 0; i < len; i++) begin
      e.x = xv[len-1-i];
      e.p = pv[len-1-i];
      e.d = (i == len - 1);
      if (sel == 1'b0) qA.push_back(e);
      else             qB.push_back(e);
    end
    @(negedge clk);
    if (sel == 1'b0) loadA = 1'b0;
    else             loadB = 1'b0;
  endtask

  // Bounded wait until every queued bit of a unit has been seen
  task automatic waitDrain(input bit sel);
    int n;
    n = 0;
    while (((sel == 1'b0) ? qA.size() : qB.size()) != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput(sel ? "B drain" : "A drain",
                16'((sel == 1'b0) ? qA.size() : qB.size()), 16'd0);
  endtask

  // Monitor A: pop the expected bit whenever a stream bit is shown, else demand idle
  always @(negedge clk) begin
    exp_t e;
    if (bvA) begin
      if (qA.size() == 0) begin
        checkOutput("A unexpected bit", 16'd1, 16'd0);
      end else begin
        e = qA.pop_front();
        checkOutput("A x_out", 16'(xA), 16'(e.x));
        checkOutput("A match_pulse", 16'(pA), 16'(e.p));
        checkOutput("A done", 16'(doneA), 16'(e.d));
        checkOutput("A busy", 16'(busyA), 16'd1);
        checkOutput("A ready", 16'(readyA), 16'(e.d));
      end
    end else begin
      checkOutput("A idle {x,pulse,done,busy,ready}",
                  16'({xA, pA, doneA, busyA, readyA}), 16'b00001);
    end
  end

  // Monitor B: same scoreboard discipline for the gapless unit
  always @(negedge clk) begin
    exp_t e;
    if (bvB) begin
      if (qB.size() == 0) begin
        checkOutput("B unexpected bit", 16'd1, 16'd0);
      end else begin
        e = qB.pop_front();
        checkOutput("B x_out", 16'(xB), 16'(e.x));
        checkOutput("B match_pulse", 16'(pB), 16'(e.p));
        checkOutput("B done", 16'(doneB), 16'(e.d));
        checkOutput("B busy", 16'(busyB), 16'd1);
        checkOutput("B ready", 16'(readyB), 16'(e.d));
      end
    end else begin
      checkOutput("B idle {x,pulse,done,busy,ready}",
                  16'({xB, pB, doneB, busyB, readyB}), 16'b00001);
    end
  end

  // Directed scenario sequence
  initial begin
    int n;
    rst   = 1'b1;
    loadA = 1'b0;
    loadB = 1'b0;
    dataA = 8'h00;
    dataB = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("A cnt in reset", 16'(cntA), 16'd0);
    checkOutput("B cnt in reset", cntB, 16'd0);
    rst = 1'b0;

    // Basic frame: A5 from clear history, pulses on bits 3 and 8
    applyStimulus(1'b0, 8'hA5, 9'b1010_0101_0, 9'b0010_0001_0, 9);
    waitDrain(1'b0);
    checkOutput("A cnt after basic", 16'(cntA), 16'd2);

    // Reset mid-frame: history is 10, so A5 would pulse on bit 1 and bit 3
    applyStimulus(1'b0, 8'hA5, 9'b1010_0101_0, 9'b1010_0001_0, 9);
    n = 0;
    while (qA.size() > 5 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("A bits before reset", 16'(qA.size()), 16'd5);
    rst   = 1'b1;
    loadA = 1'b1;
    dataA = 8'hFF;
    #1;
    checkOutput("A reset {x,valid,busy,done,pulse}",
                16'({xA, bvA, busyA, doneA, pA}), 16'd0);
    checkOutput("A reset ready", 16'(readyA), 16'd1);
    checkOutput("A reset cnt", 16'(cntA), 16'd0);
    qA.delete();
    @(negedge clk);
    @(negedge clk);
    loadA = 1'b0;
    #1;
    rst = 1'b0;

    // Restart after reset then chain 80 on the done cycle: 80's MSB completes 101
    applyStimulus(1'b0, 8'hA5, 9'b1010_0101_0, 9'b0010_0001_0, 9);
    applyStimulus(1'b0, 8'h80, 9'b1000_0000_0, 9'b1000_0000_0, 9);
    waitDrain(1'b0);
    checkOutput("A cnt after back-to-back", 16'(cntA), 16'd3);

    // Saturation with an ignored load of FF mid-frame; history is 00 here
    applyStimulus(1'b0, 8'hA5, 9'b1010_0101_0, 9'b0010_0001_0, 9);
    @(negedge clk);
    @(negedge clk);
    loadA = 1'b1;
    dataA = 8'hFF;
    @(negedge clk);
    loadA = 1'b0;
    waitDrain(1'b0);
    checkOutput("A cnt saturated", 16'(cntA), 16'd3);

    // Another frame after idle: history 10 carried over, three pulses, still saturated
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 8'hA5, 9'b1010_0101_0, 9'b1010_0001_0, 9);
    waitDrain(1'b0);
    checkOutput("A cnt held", 16'(cntA), 16'd3);

    // Gapless unit: 05 then 40 on its last bit, matches on 05 bit 8 and 40 bit 2
    applyStimulus(1'b1, 8'h05, 9'b0_0000_0101, 9'b0_0000_0001, 8);
    applyStimulus(1'b1, 8'h40, 9'b0_0100_0000, 9'b0_0100_0000, 8);
    waitDrain(1'b1);
    checkOutput("B cnt after gapless", cntB, 16'd2);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/seq101_pattern_tx.md
# seq101_pattern_tx

Serial pattern transmitter that drives the one-bit stream consumed by the team's "101" Mealy sequence detector. It accepts parallel words over a valid/ready handshake and shifts each one out MSB-first, followed by a programmable run of zero gap bits. It also tracks overlapping "101" occurrences in the emitted stream, so a bench can compare its count and pulse against the detector's `y` output cycle for cycle.

## Interface
- `WIDTH`, default 8: word length in bits; must be at least 2.
- `GAP`, default 1: number of zero bits appended after each word; 0 is legal.
- `CNT_W`, default 16: width of the match counter.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `data_in` input WIDTH: word to transmit; sampled only on handshake.
- `load` input 1: word valid.
- `ready` output 1: block can accept a word this cycle.
- `x_out` output 1: serial bit; this is the detector's `x`.
- `bit_valid` output 1: `x_out` carries a stream bit (data or gap) this cycle.
- `busy` output 1: a frame is in progress.
- `done` output 1: one-cycle pulse on the final bit of a frame.
- `match_pulse` output 1: the current `x_out` completes "101" (Mealy output).
- `match_cnt` output CNT_W: total matches since reset; saturating.

## Operation
- **Frame definition.** A frame is WIDTH data bits, MSB first, followed by GAP zero bits. Every bit of a frame has `bit_valid` = 1.
- **States.**
  - IDLE: `x_out` = 0, `bit_valid` = 0, `ready` = 1, `busy` = 0.
  - SHIFT: data bits are emitted; a down-counter `bit_idx` runs from WIDTH-1 to 0.
  - GAP: gap bits are emitted; a down-counter runs from GAP-1 to 0. This state is skipped when GAP = 0.
- **Transitions.**
  - IDLE to SHIFT on `load` && `ready`.
  - SHIFT to GAP after the last data bit, or to IDLE/SHIFT directly when GAP = 0.
  - GAP to IDLE after the last gap bit, or to SHIFT if a new word is accepted on that cycle.
- **Handshake.**
  - `ready` = 1 in IDLE and on the final bit cycle of a frame.
  - A word accepted on the final bit cycle produces a gapless continuous stream: its MSB appears on the next cycle.
  - `load` on any other cycle is ignored. No queuing, and `data_in` is not sampled.
  - `done` = 1 exactly on the final bit cycle. If a new word is accepted on that cycle, `done` and `ready` are high together.
- **Match tracking.**
  - A two-bit history `{h1,h0}` updates on every edge where `bit_valid` = 1 and is held otherwise.
  - History is not cleared between frames or in IDLE, so matches may span frame boundaries and gap bits.
  - `match_pulse` = `bit_valid` && ({h1,h0} == 2'b10) && `x_out`.
  - On each edge where `match_pulse` = 1, `match_cnt` increments. It holds at 2^CNT_W - 1.
- **Reset.**
  - Asserting `rst` mid-frame aborts the frame immediately.
  - State goes to IDLE; the shift register, counters, history and `match_cnt` clear to 0.
  - Outputs during and after reset: `x_out`, `bit_valid`, `busy`, `done` and `match_pulse` are 0, `match_cnt` is 0, and `ready` is 1.
  - `load` is ignored while `rst` = 1.

## Timing
- Load accepted at edge N: MSB is on `x_out` during cycle N+1.
- Data bit k (MSB = bit 0) is on `x_out` during cycle N+1+k.
- Last gap bit, which is also the `done` cycle, is during cycle N+WIDTH+GAP.
- `busy` = 1 from cycle N+1 through the final bit.
- `x_out`, `bit_valid`, `busy` and `done` are registered or decoded from registered state only, with no path from `load`.
- `match_pulse` is combinational from registered state only. `match_cnt` updates one edge after its pulse.
- Sustained throughput is one word per WIDTH+GAP cycles.

## Structure
- Shared package `seq101_pkg` holds:
  - the state enum (IDLE, SHIFT, GAP);
  - the match pattern constant 3'b101, reused by the detector bench.
- One sub-module, `seq101_tracker`, contains the history register, `match_pulse` and the saturating `match_cnt`. Its ports are `clk`, `rst`, `bit_valid`, `x_out`, `match_pulse` and `match_cnt`.
- The top level holds the FSM, the shift register and the bit/gap counter.

## Test plan
- **Basic frame.** WIDTH = 8, GAP = 1; load 8'hA5 at edge 0 → `x_out` over cycles 1–9 = 1,0,1,0,0,1,0,1,0. `match_pulse` is high in cycles 3 and 8. `done` is high in cycle 9 and `match_cnt` = 2 afterwards.
- **Back-to-back across boundary.** Load 8'hA5, then 8'h80 on the `done`/`ready` cycle → no idle gap; 8'h80's MSB sits at cycle 10. `match_pulse` fires in cycle 10 (history 1,0 then 1) and `match_cnt` = 3.
- **GAP = 0 continuous stream.** Load 8'h05, then 8'h40 on its last bit → matches on the last bit of word 1 and on bit 2 of word 2; `match_cnt` = 2.
- **Ignored load.** Pulse `load` with 8'hFF during SHIFT → stream unchanged and `ready` stays 0 until the final bit.
- **Reset mid-frame.** Assert `rst` during data bit 4 → all outputs go to reset values in that cycle and `match_cnt` = 0. The next load restarts cleanly, with history cleared.
- **Saturation.** CNT_W = 2; stream four frames of 8'hA5 → `match_cnt` holds at 3 while `match_pulse` keeps firing.
